// File: rtl/team_id_snapshot.sv
// team_id_snapshot: debounced multi-word team-ID reader on the 16-bit peripheral bus.
// The radio ID bus is synchronised and must hold steady for STABLE_CYCLES before it is
// copied into an atomic snapshot, so software always reads a coherent multi-word value.
// Change detection, a saturating change counter, manual/automatic capture and a level
// interrupt are provided.
module team_id_snapshot #(
    parameter logic [14:0] BASE_ADDR     = 15'h01B0,
    parameter int          DEC_WD        = 4,
    parameter int          NUM_WORDS     = 2,
    parameter int          STABLE_CYCLES = 16
) (
    input  logic                   mclk,
    input  logic                   puc_rst,
    input  logic [13:0]            per_addr,
    input  logic [15:0]            per_din,
    input  logic                   per_en,
    input  logic [1:0]             per_we,
    input  logic [16*NUM_WORDS-1:0] id_in,
    output logic [15:0]            per_dout,
    output logic                   irq_id_chg
);

    localparam int ID_W     = 16 * NUM_WORDS;
    localparam int CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam int OFF_W    = DEC_WD - 1;          // word-offset bits inside the window
    localparam int NUM_REGS = 2 ** OFF_W;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    // Word offsets of the fixed registers; ID words follow from ID_BASE upward.
    localparam logic [OFF_W-1:0] OFF_CTL  = OFF_W'(0);
    localparam logic [OFF_W-1:0] OFF_STAT = OFF_W'(1);
    localparam int               ID_BASE  = 2;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             reg_sel;
    logic             reg_rd;
    logic             reg_wr_lo;
    logic [OFF_W-1:0] word_off;
    logic             ctl_wr;
    logic             stat_wr;

    assign reg_sel   = per_en && (per_addr[13:DEC_WD-1] == BASE_ADDR[14:DEC_WD]);
    assign word_off  = per_addr[OFF_W-1:0];
    assign reg_rd    = reg_sel && (per_we == 2'b00);
    // Only the low byte carries control/status bits, so a high-byte-only write does nothing.
    assign reg_wr_lo = reg_sel && per_we[0];
    assign ctl_wr    = reg_wr_lo && (word_off == OFF_CTL);
    assign stat_wr   = reg_wr_lo && (word_off == OFF_STAT);

    // Upper write-data bits carry no register fields.
    logic unused_din;
    assign unused_din = ^per_din[15:3];

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]  s1_reg;
    logic [ID_W-1:0]  s2_reg;
    logic [ID_W-1:0]  s_prev_reg;
    logic [ID_W-1:0]  snap_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             ie_reg;
    logic             auto_reg;
    logic             cap_pend_reg;
    logic             valid_reg;
    logic             chg_reg;
    logic [7:0]       chg_cnt_reg;

    logic             stable;
    logic             differs;
    logic             cap_fire;
    logic             cap_req;

    // Two-flop synchroniser plus a one-cycle history used to detect movement.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            s1_reg     <= '0;
            s2_reg     <= '0;
            s_prev_reg <= '0;
        end else begin
            s1_reg     <= id_in;
            s2_reg     <= s1_reg;
            s_prev_reg <= s2_reg;
        end
    end

    assign stable = (s2_reg == s_prev_reg);

    // Stability count: restarts on any movement, saturates at the required length.
    always_comb begin
        cnt_next = cnt_reg;
        if (!stable) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Register the stability count.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Capture fires on a settled value that is new (or the first one) and is wanted.
    // cap_pend is used as registered, so a CAP write in the capture cycle waits one cycle.
    assign differs  = (s2_reg != snap_reg) || !valid_reg;
    assign cap_req  = auto_reg || cap_pend_reg;
    assign cap_fire = (cnt_reg == CNT_MAX) && stable && differs && cap_req;

    // Snapshot and its VALID flag.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            snap_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (cap_fire) begin
            snap_reg  <= s2_reg;
            valid_reg <= 1'b1;
        end
    end

    // Control bits IE/AUTO and the pending manual capture request.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            ie_reg       <= 1'b0;
            auto_reg     <= 1'b0;
            cap_pend_reg <= 1'b0;
        end else begin
            if (ctl_wr) begin
                ie_reg   <= per_din[0];
                auto_reg <= per_din[1];
            end
            // A fresh CAP write outranks the clear from a capture in the same cycle.
            if (ctl_wr && per_din[2]) begin
                cap_pend_reg <= 1'b1;
            end else if (cap_fire) begin
                cap_pend_reg <= 1'b0;
            end
        end
    end

    // Change flag (write-1-to-clear, set wins) and saturating change counter.
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            chg_reg     <= 1'b0;
            chg_cnt_reg <= 8'd0;
        end else begin
            if (cap_fire && valid_reg) begin
                chg_reg <= 1'b1;
                if (chg_cnt_reg != 8'hFF) begin
                    chg_cnt_reg <= chg_cnt_reg + 8'd1;
                end
            end else if (stat_wr && per_din[1]) begin
                chg_reg <= 1'b0;
            end
        end
    end

    assign irq_id_chg = ie_reg && chg_reg;

    // ------------------------------------------------------------------
    // Read mux: one entry per word offset of the decode window
    // ------------------------------------------------------------------
    logic [15:0] rd_val [NUM_REGS];

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_rd
            if (gi == 0) begin : g_ctl
                assign rd_val[gi] = {14'd0, auto_reg, ie_reg};
            end else if (gi == 1) begin : g_stat
                assign rd_val[gi] = {chg_cnt_reg, 6'd0, chg_reg, valid_reg};
            end else if ((gi - ID_BASE) < NUM_WORDS) begin : g_id
                assign rd_val[gi] = snap_reg[(gi-ID_BASE)*16 +: 16];
            end else begin : g_none
                assign rd_val[gi] = 16'd0;
            end
        end
    endgenerate

    assign per_dout = reg_rd ? rd_val[word_off] : 16'd0;

endmodule

// File: tb/tb_team_id_snapshot.sv
// Directed bench for team_id_snapshot with hand-computed expected values.
module tb_team_id_snapshot;

    localparam logic [13:0] A_CTL  = 14'h00D8;
    localparam logic [13:0] A_STAT = 14'h00D9;
    localparam logic [13:0] A_ID0  = 14'h00DA;
    localparam logic [13:0] A_ID1  = 14'h00DB;
    localparam logic [13:0] A_OFF8 = 14'h00DC;
    localparam logic [13:0] A_OUT  = 14'h00E0;

    logic        mclk;
    logic        puc_rst;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [31:0] id_in;
    logic [15:0] per_dout;
    logic        irq_id_chg;

    int n_checks = 0;
    int n_fail   = 0;

    team_id_snapshot #(
        .BASE_ADDR(15'h01B0),
        .DEC_WD(4),
        .NUM_WORDS(2),
        .STABLE_CYCLES(16)
    ) dut (
        .mclk(mclk),
        .puc_rst(puc_rst),
        .per_addr(per_addr),
        .per_din(per_din),
        .per_en(per_en),
        .per_we(per_we),
        .id_in(id_in),
        .per_dout(per_dout),
        .irq_id_chg(irq_id_chg)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic bus_write(input logic [13:0] addr, input logic [15:0] data, input logic [1:0] we);
        @(negedge mclk);
        per_en   = 1'b1;
        per_addr = addr;
        per_din  = data;
        per_we   = we;
        @(negedge mclk);
        per_en   = 1'b0;
        per_we   = 2'b00;
    endtask

    task automatic bus_read(input logic [13:0] addr, output logic [15:0] data);
        @(negedge mclk);
        per_en   = 1'b1;
        per_we   = 2'b00;
        per_addr = addr;
        #1;
        data = per_dout;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    logic [15:0] rd;

    initial begin
        puc_rst  = 1'b1;
        per_en   = 1'b0;
        per_we   = 2'b00;
        per_addr = 14'd0;
        per_din  = 16'd0;
        id_in    = 32'h1234_5678;
        repeat (4) @(negedge mclk);
        #1;
        check_val("rst_dout", per_dout, 16'h0000);
        check_val("rst_irq", {15'd0, irq_id_chg}, 16'h0000);
        puc_rst = 1'b0;

        // --- manual capture with AUTO=0 ---
        bus_read(A_CTL, rd);  check_val("rst_ctl", rd, 16'h0000);
        bus_read(A_STAT, rd); check_val("rst_stat", rd, 16'h0000);
        repeat (40) @(negedge mclk);
        bus_read(A_STAT, rd); check_val("noauto_stat", rd, 16'h0000);
        bus_read(A_ID0, rd);  check_val("noauto_id0", rd, 16'h0000);
        bus_write(A_CTL, 16'h0004, 2'b11);
        bus_read(A_STAT, rd); check_val("cap_stat", rd, 16'h0001);
        bus_read(A_ID0, rd);  check_val("cap_id0", rd, 16'h5678);
        bus_read(A_ID1, rd);  check_val("cap_id1", rd, 16'h1234);
        bus_read(A_CTL, rd);  check_val("cap_ctl_rd0", rd, 16'h0000);

        // --- automatic capture latency ---
        bus_write(A_CTL, 16'h0003, 2'b01);
        bus_read(A_CTL, rd);  check_val("ctl_ie_auto", rd, 16'h0003);
        @(negedge mclk);
        id_in    = 32'hAAAA_5555;
        per_addr = A_ID0;
        per_en   = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge mclk);
            if (i == 19) check_val("lat_e19", per_dout, 16'h5678);
            if (i == 20) check_val("lat_e20", per_dout, 16'h5555);
        end
        bus_read(A_ID1, rd);  check_val("auto_id1", rd, 16'hAAAA);
        bus_read(A_STAT, rd); check_val("auto_stat", rd, 16'h0103);
        check_val("auto_irq", {15'd0, irq_id_chg}, 16'h0001);
        bus_write(A_STAT, 16'h0002, 2'b01);
        bus_read(A_STAT, rd); check_val("w1c_stat", rd, 16'h0101);
        check_val("w1c_irq", {15'd0, irq_id_chg}, 16'h0000);

        // --- bouncing input: no capture until it settles ---
        @(negedge mclk);
        per_addr = A_ID0;
        for (int t = 0; t < 11; t++) begin
            if (t == 10) begin
                #1;
                check_val("bounce_id0", per_dout, 16'h5555);
                per_addr = A_STAT;
                #1;
                check_val("bounce_stat", per_dout, 16'h0101);
                per_addr = A_ID0;
            end
            id_in[0] = ~id_in[0];
            if (t < 10) repeat (10) @(negedge mclk);
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge mclk);
            if (i == 19) check_val("settle_e19", per_dout, 16'h5555);
            if (i == 20) check_val("settle_e20", per_dout, 16'h5554);
        end
        bus_read(A_STAT, rd); check_val("settle_stat", rd, 16'h0203);

        // --- byte enables and map ---
        bus_write(A_CTL, 16'h0000, 2'b10);
        bus_read(A_CTL, rd);  check_val("hi_byte_ctl", rd, 16'h0003);
        bus_read(A_OFF8, rd); check_val("off8", rd, 16'h0000);
        bus_write(A_ID0, 16'hFFFF, 2'b11);
        bus_read(A_ID0, rd);  check_val("id0_ro", rd, 16'h5554);
        bus_read(A_OUT, rd);  check_val("out_window", rd, 16'h0000);
        @(negedge mclk);
        per_en   = 1'b0;
        per_addr = A_CTL;
        #1;
        check_val("en_low", per_dout, 16'h0000);

        // --- W1C in the same cycle as a capture: set wins ---
        @(negedge mclk);
        id_in = 32'h0000_1111;
        repeat (19) @(negedge mclk);
        per_en   = 1'b1;
        per_addr = A_STAT;
        per_din  = 16'h0002;
        per_we   = 2'b01;
        @(negedge mclk);
        per_en   = 1'b0;
        per_we   = 2'b00;
        bus_read(A_STAT, rd); check_val("same_cyc_stat", rd, 16'h0303);
        bus_read(A_ID0, rd);  check_val("same_cyc_id0", rd, 16'h1111);

        // --- change counter saturation ---
        for (int k = 0; k < 256; k++) begin
            @(negedge mclk);
            id_in = (k % 2 == 0) ? 32'h0000_2222 : 32'h0000_3333;
            repeat (22) @(negedge mclk);
            if (k == 251) begin
                bus_read(A_STAT, rd); check_val("cnt_255", rd, 16'hFF03);
            end
        end
        bus_read(A_STAT, rd); check_val("cnt_sat", rd, 16'hFF03);
        bus_read(A_ID0, rd);  check_val("sat_id0", rd, 16'h3333);

        // --- reset mid-count and mid-write ---
        @(negedge mclk);
        per_en = 1'b0;
        id_in  = 32'h0000_4444;
        repeat (11) @(negedge mclk);
        puc_rst  = 1'b1;
        per_en   = 1'b1;
        per_addr = A_CTL;
        per_din  = 16'h0003;
        per_we   = 2'b01;
        @(negedge mclk);
        puc_rst  = 1'b0;
        per_en   = 1'b0;
        per_we   = 2'b00;
        bus_read(A_CTL, rd);  check_val("rst2_ctl", rd, 16'h0000);
        bus_read(A_STAT, rd); check_val("rst2_stat", rd, 16'h0000);
        bus_read(A_ID0, rd);  check_val("rst2_id0", rd, 16'h0000);
        bus_read(A_ID1, rd);  check_val("rst2_id1", rd, 16'h0000);
        check_val("rst2_irq", {15'd0, irq_id_chg}, 16'h0000);
        bus_write(A_CTL, 16'h0002, 2'b01);
        repeat (40) @(negedge mclk);
        bus_read(A_STAT, rd); check_val("post_rst_stat", rd, 16'h0001);
        bus_read(A_ID0, rd);  check_val("post_rst_id0", rd, 16'h4444);
        bus_read(A_ID1, rd);  check_val("post_rst_id1", rd, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
